// File: rtl/cv32e40p_tb_obi_mem_arbiter.sv
// Multi-port OBI memory responder: round-robin arbitration onto one shared word RAM
// with fixed response latency, per-port outstanding limit and a pass/fail/exit MMIO window.
module cv32e40p_tb_obi_mem_arbiter #(
    parameter int unsigned NUM_PORTS       = 2,
    parameter int unsigned ADDR_WIDTH      = 20,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] MMIO_BASE       = 32'h2000_0000,
    parameter logic [31:0] PASS_MAGIC      = 32'd123456789
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_PORTS-1:0]    req_i,
    output logic [NUM_PORTS-1:0]    gnt_o,
    input  logic [NUM_PORTS*32-1:0] addr_i,
    input  logic [NUM_PORTS-1:0]    we_i,
    input  logic [NUM_PORTS*4-1:0]  be_i,
    input  logic [NUM_PORTS*32-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]    rvalid_o,
    output logic [NUM_PORTS*32-1:0] rdata_o,
    output logic                    err_o,
    output logic                    tests_passed_o,
    output logic                    tests_failed_o,
    output logic                    exit_valid_o,
    output logic [31:0]             exit_value_o
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned WORDS = 32'd1 << (ADDR_WIDTH - 2);
    localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;

    logic [PTR_W-1:0]      r_rr_ptr;
    logic [CNT_W-1:0]      r_outstanding [NUM_PORTS];
    logic                  r_vld         [NUM_PORTS][RESP_LATENCY];
    logic [31:0]           r_dat         [NUM_PORTS][RESP_LATENCY];
    logic [31:0]           r_mem         [WORDS];

    logic [31:0]           w_addr_a  [NUM_PORTS];
    logic [31:0]           w_wdata_a [NUM_PORTS];
    logic [3:0]            w_be_a    [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_elig;
    logic [NUM_PORTS-1:0]  w_gnt;
    logic                  w_gnt_found;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic [31:0]           w_addr;
    logic [31:0]           w_wdata;
    logic [31:0]           w_rdata;
    logic [31:0]           w_mmio_off;
    logic [3:0]            w_be;
    logic                  w_we;
    logic                  w_is_mmio;
    logic                  w_is_ram;
    logic [ADDR_WIDTH-3:0] w_word;

    // Response outputs come straight from the last pipeline stage
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rvalid_o[p]         = r_vld[p][RESP_LATENCY-1];
            rdata_o[32*p +: 32] = r_dat[p][RESP_LATENCY-1];
        end
    end

    // A port at its limit is still eligible when a response frees a slot this cycle
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_addr_a[p]  = addr_i[32*p +: 32];
            w_wdata_a[p] = wdata_i[32*p +: 32];
            w_be_a[p]    = be_i[4*p +: 4];
            w_elig[p]    = req_i[p] &&
                           ((r_outstanding[p] < CNT_W'(MAX_OUTSTANDING)) || rvalid_o[p]);
        end
    end

    // Round-robin search starting at r_rr_ptr
    always_comb begin
        int unsigned v_idx;
        v_idx       = 0;
        w_gnt       = '0;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            v_idx = (32'(r_rr_ptr) + i) % NUM_PORTS;
            if (!w_gnt_found && w_elig[PTR_W'(v_idx)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = PTR_W'(v_idx);
            end
        end
        if (w_gnt_found) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign gnt_o = w_gnt;

    // Granted access decode and read data
    always_comb begin
        w_addr     = w_addr_a[w_gnt_idx];
        w_wdata    = w_wdata_a[w_gnt_idx];
        w_be       = w_be_a[w_gnt_idx];
        w_we       = we_i[w_gnt_idx];
        w_mmio_off = w_addr - MMIO_BASE;
        w_is_mmio  = (w_addr >= MMIO_BASE) && (w_mmio_off < 32'd8);
        w_is_ram   = !w_is_mmio && ((w_addr >> ADDR_WIDTH) == 32'd0);
        w_word     = w_addr[ADDR_WIDTH-1:2];
        w_rdata    = '0;
        if (!w_we) begin
            if (w_is_ram) begin
                w_rdata = r_mem[w_word];
            end else if (!w_is_mmio) begin
                w_rdata = OOR_RDATA;
            end
        end
    end

    // RAM contents survive reset
    always_ff @(posedge clk_i) begin
        if (w_gnt_found && w_we && w_is_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_word][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr       <= '0;
            err_o          <= 1'b0;
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_outstanding[p] <= '0;
                for (int s = 0; s < RESP_LATENCY; s++) begin
                    r_vld[p][s] <= 1'b0;
                    r_dat[p][s] <= '0;
                end
            end
        end else begin
            exit_valid_o <= 1'b0;
            if (w_gnt_found) begin
                r_rr_ptr <= (w_gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : w_gnt_idx + 1'b1;
                if (w_is_mmio && w_we) begin
                    if (!w_mmio_off[2]) begin
                        if (w_wdata == PASS_MAGIC) begin
                            tests_passed_o <= 1'b1;
                        end else begin
                            tests_failed_o <= 1'b1;
                        end
                    end else begin
                        exit_value_o <= w_wdata;
                        exit_valid_o <= 1'b1;
                    end
                end
                if (!w_is_mmio && !w_is_ram) begin
                    err_o <= 1'b1;
                end
            end
            // Per-port response shift pipeline and outstanding bookkeeping
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int s = RESP_LATENCY - 1; s > 0; s--) begin
                    r_vld[p][s] <= r_vld[p][s-1];
                    r_dat[p][s] <= r_dat[p][s-1];
                end
                r_vld[p][0] <= w_gnt[p];
                r_dat[p][0] <= w_gnt[p] ? w_rdata : '0;
                case ({w_gnt[p], rvalid_o[p]})
                    2'b10:   r_outstanding[p] <= r_outstanding[p] + CNT_W'(1);
                    2'b01:   r_outstanding[p] <= r_outstanding[p] - CNT_W'(1);
                    default: r_outstanding[p] <= r_outstanding[p];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_tb_obi_mem_arbiter.sv
// Directed bench for the OBI memory arbiter: scoreboarded responses on a latency-1
// instance plus a latency-4 instance for outstanding-limit throttling and reset.
module tb_cv32e40p_tb_obi_mem_arbiter;

    localparam logic [31:0] MMIO  = 32'h2000_0000;
    localparam logic [31:0] MAGIC = 32'd123456789;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, gnt, we, rvalid;
    logic [63:0] addr, wdata, rdata;
    logic [7:0]  be;
    logic        err, passed, failed, exv;
    logic [31:0] exval;

    logic [1:0]  req4, gnt4, rvalid4;
    logic [63:0] addr4, wdata4, rdata4;
    logic        err4, passed4, failed4, exv4;
    logic [31:0] exval4;

    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [31:0] mem_m [int];
    int          rr_m  = 0;
    int          cyc   = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    bit          exp_g4 [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit          exp_v4 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cv32e40p_tb_obi_mem_arbiter dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .tests_passed_o(passed), .tests_failed_o(failed), .exit_valid_o(exv),
        .exit_value_o(exval)
    );

    cv32e40p_tb_obi_mem_arbiter #(.ADDR_WIDTH(12), .RESP_LATENCY(4), .MAX_OUTSTANDING(2)) dut4 (
        .clk_i(clk), .rst_i(rst), .req_i(req4), .gnt_o(gnt4), .addr_i(addr4), .we_i(2'b00),
        .be_i(8'hFF), .wdata_i(wdata4), .rvalid_o(rvalid4), .rdata_o(rdata4), .err_o(err4),
        .tests_passed_o(passed4), .tests_failed_o(failed4), .exit_valid_o(exv4),
        .exit_value_o(exval4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic drv(input int p, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
        req[p]           = r;
        we[p]            = w;
        addr[32*p +: 32] = a;
        be[4*p +: 4]     = b;
        wdata[32*p +: 32] = d;
    endtask

    // One cycle on the main instance: check grant against the model, push the expected response
    task automatic tick();
        logic [1:0]  eg;
        logic [31:0] a, e, w;
        int          p, k;
        exp_t        x;
        @(negedge clk);
        eg = 2'b00;
        p  = -1;
        for (int i = 0; i < 2; i++) begin
            k = (rr_m + i) % 2;
            if (p < 0 && req[k]) p = k;
        end
        if (p >= 0) eg[p] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        if (p >= 0) begin
            a = addr[32*p +: 32];
            e = 32'h0;
            if (a >= MMIO && a < MMIO + 32'd8) begin
                e = 32'h0;
            end else if (a[31:20] == 12'h0) begin
                k = int'(a[19:2]);
                if (we[p]) begin
                    w = mem_m.exists(k) ? mem_m[k] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (be[4*p + b]) w[8*b +: 8] = wdata[32*p + 8*b +: 8];
                    mem_m[k] = w;
                end else begin
                    e = mem_m.exists(k) ? mem_m[k] : 32'h0;
                end
            end else begin
                e = we[p] ? 32'h0 : 32'hDEAD_BEEF;
            end
            x.data = e;
            x.due  = cyc + 1;
            if (p == 0) sb0.push_back(x); else sb1.push_back(x);
            rr_m = (p + 1) % 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mon(input int p, input logic v, input logic [31:0] d);
        exp_t x;
        bit   have;
        have = (p == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
        if (have) x = (p == 0) ? sb0[0] : sb1[0];
        if (v || have) begin
            if (v || x.due <= cyc)
                chk(p == 0 ? "rvalid0" : "rvalid1", 32'(v), 32'(have && x.due == cyc));
            if (v && have) begin
                chk(p == 0 ? "rdata0" : "rdata1", d, x.data);
                if (p == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
            end else if (have && x.due <= cyc) begin
                if (p == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, rvalid[0], rdata[31:0]);
            mon(1, rvalid[1], rdata[63:32]);
        end
    end

    initial begin
        rst = 1'b1;
        req = '0; we = '0; addr = '0; be = '0; wdata = '0;
        req4 = '0; addr4 = '0; wdata4 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata", rdata[31:0] | rdata[63:32], 32'h0);
        chk("rst_flags", 32'({err, passed, failed, exv}), 32'h0);
        chk("rst_exval", exval, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Alternating grants, byte-enable write then read by the other port
        drv(0, 1, 1, 32'h100, 4'hF, 32'h1111_1111);
        drv(1, 1, 0, 32'h100, 4'hF, 32'h0);
        tick();
        drv(0, 1, 1, 32'h100, 4'b0101, 32'hA5A5_A5A5);
        tick();
        tick();
        drv(0, 1, 1, MMIO, 4'hF, MAGIC);
        tick();
        drv(1, 1, 0, 32'h4000_0000, 4'hF, 32'h0);
        tick();
        chk("passed", 32'(passed), 32'h1);
        chk("failed_clear", 32'(failed), 32'h0);
        chk("err_clear", 32'(err), 32'h0);
        drv(0, 1, 1, MMIO + 32'd4, 4'hF, 32'd7);
        tick();
        chk("err_set", 32'(err), 32'h1);
        drv(1, 1, 0, MMIO, 4'hF, 32'h0);
        tick();
        chk("exit_pulse", 32'(exv), 32'h1);
        chk("exit_value", exval, 32'd7);
        drv(0, 0, 0, 32'h0, 4'h0, 32'h0);
        tick();
        chk("exit_pulse_end", 32'(exv), 32'h0);
        chk("exit_value_hold", exval, 32'd7);
        drv(0, 1, 1, MMIO, 4'hF, 32'd5);
        drv(1, 0, 0, 32'h0, 4'h0, 32'h0);
        tick();
        chk("failed_set", 32'(failed), 32'h1);
        chk("passed_hold", 32'(passed), 32'h1);
        chk("err_sticky", 32'(err), 32'h1);
        drv(0, 1, 0, 32'h100, 4'hF, 32'h0);
        drv(1, 1, 1, 32'h5000_0000, 4'hF, 32'h1234_5678);
        tick();
        drv(1, 0, 0, 32'h0, 4'h0, 32'h0);
        tick();
        drv(0, 0, 0, 32'h0, 4'h0, 32'h0);
        tick();
        tick();

        // Outstanding limit throttles a latency-4 port
        req4 = 2'b01;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("gnt4", 32'(gnt4), 32'({1'b0, exp_g4[c]}));
            chk("rvalid4", 32'(rvalid4), 32'({1'b0, exp_v4[c]}));
            @(posedge clk); #1;
        end

        // Reset with two responses in flight on the latency-4 instance
        rst  = 1'b1;
        req4 = 2'b00;
        sb0.delete();
        sb1.delete();
        rr_m = 0;
        @(negedge clk);
        chk("rst2_rvalid4", 32'(rvalid4), 32'h0);
        chk("rst2_flags", 32'({err, passed, failed, exv}), 32'h0);
        chk("rst2_exval", exval, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("drop_rvalid4", 32'(rvalid4), 32'h0);
            @(posedge clk); #1;
        end
        req4 = 2'b11;
        @(negedge clk);
        chk("first_gnt4", 32'(gnt4), 32'h1);
        @(posedge clk); #1;
        req4 = 2'b00;
        drv(0, 1, 0, 32'h100, 4'hF, 32'h0);
        drv(1, 1, 0, 32'h100, 4'hF, 32'h0);
        tick();
        tick();
        drv(0, 0, 0, 32'h0, 4'h0, 32'h0);
        drv(1, 0, 0, 32'h0, 4'h0, 32'h0);
        tick();
        tick();
        chk("sb_drain", 32'(sb0.size() + sb1.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
